// File: rtl/dispatch_ctrl.sv
// rtl/dispatch_ctrl.sv - instruction queue and in-order dispatch sequencer between fetch and decode
module dispatch_ctrl #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_fetch_valid,
    input  logic [31:0] in_fetch_instr,
    input  logic [31:0] in_fetch_pc,
    output logic        out_fetch_full,
    input  logic        in_rob_full,
    input  logic        in_rs_full,
    input  logic        in_lsb_full,
    input  logic        in_flush,
    output logic        out_dec_valid,
    output logic [31:0] out_dec_instr,
    output logic [31:0] out_dec_pc,
    output logic [1:0]  out_dec_unit
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [1:0]        UNIT_RS    = 2'b01;
    localparam logic [1:0]        UNIT_LSB   = 2'b10;
    localparam logic [6:0]        OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]        OPC_STORE  = 7'b0100011;
    localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(DEPTH);

    state_t             state;
    state_t             state_nxt;

    logic [31:0]        q_instr [DEPTH];
    logic [31:0]        q_pc    [DEPTH];
    logic [ADDR_W-1:0]  head;
    logic [ADDR_W-1:0]  tail;
    logic [ADDR_W:0]    count;
    logic [ADDR_W:0]    count_nxt;

    logic [31:0]        head_instr;
    logic [31:0]        head_pc;
    logic [6:0]         head_opcode;
    logic [1:0]         head_unit;
    logic               unit_blocked;
    logic               do_enq;
    logic               do_deq;

    // Classify the head entry and decide whether it may leave this cycle
    always_comb begin
        head_instr   = q_instr[head];
        head_pc      = q_pc[head];
        head_opcode  = head_instr[6:0];
        head_unit    = UNIT_RS;
        if (head_opcode == OPC_LOAD || head_opcode == OPC_STORE) begin
            head_unit = UNIT_LSB;
        end
        unit_blocked = (head_unit == UNIT_LSB) ? in_lsb_full : in_rs_full;
        do_enq = (state == RUN) && !in_flush && in_fetch_valid && (count != COUNT_FULL);
        do_deq = (state == RUN) && !in_flush && (count != '0) && !in_rob_full && !unit_blocked;
    end

    // Occupancy after this edge; full/empty come from the count, never from pointer compare
    always_comb begin
        count_nxt = count;
        case ({do_enq, do_deq})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Flush FSM next state: a flush request always lands in FLUSH, otherwise return to RUN
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     state_nxt = in_flush ? FLUSH : RUN;
            FLUSH:   state_nxt = in_flush ? FLUSH : RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Flush FSM state register, frozen while rdy is low
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
        end else if (rdy) begin
            state <= state_nxt;
        end
    end

    // Queue storage; contents need no reset because count qualifies every read
    always_ff @(posedge clk) begin
        if (rst && rdy && do_enq) begin
            q_instr[tail] <= in_fetch_instr;
            q_pc[tail]    <= in_fetch_pc;
        end
    end

    // Pointers, occupancy and the registered dispatch port
    always_ff @(posedge clk) begin
        if (!rst) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            out_fetch_full <= 1'b0;
            out_dec_valid  <= 1'b0;
            out_dec_instr  <= '0;
            out_dec_pc     <= '0;
            out_dec_unit   <= 2'b00;
        end else if (rdy) begin
            if (in_flush) begin
                head           <= '0;
                tail           <= '0;
                count          <= '0;
                out_fetch_full <= 1'b0;
                out_dec_valid  <= 1'b0;
            end else begin
                if (do_enq) begin
                    tail <= tail + 1'b1;
                end
                if (do_deq) begin
                    head          <= head + 1'b1;
                    out_dec_instr <= head_instr;
                    out_dec_pc    <= head_pc;
                    out_dec_unit  <= head_unit;
                end
                out_dec_valid  <= do_deq;
                count          <= count_nxt;
                out_fetch_full <= (count_nxt == COUNT_FULL);
            end
        end
    end

endmodule
